// File: rtl/mem_model_pkg.sv
// Shared definitions for the memory-model burst transmitter.
package mem_model_pkg;

   // FSM state encoding
   localparam logic IDLE  = 1'b0;
   localparam logic BURST = 1'b1;

   // Command word layout {len, addr}
   localparam int unsigned CMD_ADDR_LSB = 0;
   localparam int unsigned CMD_LEN_LSB  = 32;

   localparam int unsigned BOUNDARY_4K = 4096;

   // True when a burst starting at page offset off and spanning span bytes runs past the page end.
   function automatic logic crosses_4k(input logic [11:0] off, input logic [31:0] span);
      return (32'(off) + span) > 32'(BOUNDARY_4K);
   endfunction

endpackage

// File: rtl/mem_model_burst_tx_obuf.sv
// Output skid FIFO holding {last, data} beats between the memory read port and the tx stream.
module mem_model_burst_tx_obuf #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 33,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= push_data;
   end

   assign head = store[rd_ptr];

endmodule

// File: rtl/mem_model_burst_tx.sv
// Burst transmitter: pops {len, addr} commands, reads words from the memory model, streams beats out.
// Optional 4 KB boundary checker enabled by MEM_MODEL_BURST_TX_BOUNDARY_CHK_EN.
module mem_model_burst_tx
   import mem_model_pkg::*;
#(
   parameter int unsigned ADDRW      = 32,
   parameter int unsigned LENW       = 12,
   parameter int unsigned DATAW      = 32,
   parameter int unsigned ADDR_INC   = 4,
   parameter int unsigned OBUF_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_empty,
   input  logic [LENW+ADDRW-1:0] cmd_rdata,
   output logic                  cmd_read,
   output logic                  mem_rd,
   output logic [ADDRW-1:0]      mem_addr,
   input  logic [DATAW-1:0]      mem_rdata,
   output logic                  tx_valid,
   output logic [DATAW-1:0]      tx_data,
   output logic                  tx_last,
   input  logic                  tx_ready,
   output logic                  busy
`ifdef MEM_MODEL_BURST_TX_BOUNDARY_CHK_EN
   ,
   output logic                  burst_err
`endif
);

   localparam int unsigned CW     = $clog2(OBUF_DEPTH + 1);
   localparam int unsigned OW     = CW + 1;
   localparam int unsigned LEN_LO = CMD_ADDR_LSB + ADDRW;

   logic             state;
   logic             state_nxt;
   logic [ADDRW-1:0] addr_q;
   logic [LENW-1:0]  rem_q;
   logic             rd_pending;
   logic             rd_last;
   logic [ADDRW-1:0] cmd_addr;
   logic [LENW-1:0]  cmd_len;
   logic [CW-1:0]    obuf_count;
   logic [DATAW:0]   obuf_head;
   logic [OW-1:0]    occupancy;
   logic             beat_pop;
   logic             issue_ok;
   logic             last_issue;

   assign cmd_addr = cmd_rdata[CMD_ADDR_LSB +: ADDRW];
   assign cmd_len  = cmd_rdata[LEN_LO +: LENW];

   assign beat_pop   = tx_valid & tx_ready;
   // Count the outstanding read as occupied so its data always finds a free slot.
   assign occupancy  = OW'(obuf_count) + OW'(rd_pending) - OW'(beat_pop);
   assign issue_ok   = occupancy < OW'(OBUF_DEPTH);
   assign last_issue = (rem_q == LENW'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!cmd_empty && (cmd_len != '0)) state_nxt = BURST;
         BURST:   if (issue_ok && last_issue) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_read = 1'b0;
      mem_rd   = 1'b0;
      case (state)
         IDLE:    cmd_read = !cmd_empty;
         BURST:   mem_rd   = issue_ok;
         default: ;
      endcase
   end

   // Burst address/length tracking and the one-deep read-in-flight tag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q     <= '0;
         rem_q      <= '0;
         rd_pending <= 1'b0;
         rd_last    <= 1'b0;
      end else begin
         if (cmd_read) begin
            addr_q <= cmd_addr;
            rem_q  <= cmd_len;
         end else if (mem_rd) begin
            addr_q <= addr_q + ADDRW'(ADDR_INC);
            rem_q  <= rem_q - LENW'(1);
         end
         rd_pending <= mem_rd;
         rd_last    <= mem_rd & last_issue;
      end
   end

   assign mem_addr = addr_q;

   mem_model_burst_tx_obuf #(
      .DEPTH (OBUF_DEPTH),
      .WIDTH (DATAW + 1),
      .CW    (CW)
   ) u_obuf (
      .clk       (clk),
      .reset     (reset),
      .push      (rd_pending),
      .push_data ({rd_last, mem_rdata}),
      .pop       (beat_pop),
      .count     (obuf_count),
      .head      (obuf_head)
   );

   // Head is gated so an empty buffer presents zero data and no last flag.
   assign tx_valid = (obuf_count != '0);
   assign tx_data  = tx_valid ? obuf_head[DATAW-1:0] : '0;
   assign tx_last  = tx_valid & obuf_head[DATAW];

   assign busy = (state != IDLE) | rd_pending | (obuf_count != '0);

`ifdef MEM_MODEL_BURST_TX_BOUNDARY_CHK_EN
   logic [31:0] burst_span;
   assign burst_span = 32'(cmd_len) * 32'(ADDR_INC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) burst_err <= 1'b0;
      else if (cmd_read && crosses_4k(cmd_addr[11:0], burst_span)) burst_err <= 1'b1;
   end
`endif

endmodule
